// File: rtl/pcs_receive.sv
// pcs_receive: 1000BASE-X PCS receive stage.
// 8b/10b decode, simplified receive FSM, saturating invalid-code counter.
module pcs_receive #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 mr_main_reset,
  input  logic                 code_sync_status,
  input  logic                 rx_even,
  input  logic [9:0]           SUDI,
  output logic [7:0]           RXD,
  output logic                 RX_DV,
  output logic                 RX_ER,
  output logic                 receiving,
  output logic [ERR_CNT_W-1:0] invalid_count
);

  typedef enum logic [2:0] {
    S_LINK_FAILED,
    S_WAIT_FOR_K,
    S_RX_K,
    S_IDLE_D,
    S_RECEIVE,
    S_T_SEEN
  } state_t;

  typedef enum logic [2:0] {
    C_DATA,
    C_COMMA,
    C_S,
    C_T,
    C_R,
    C_OTHK,
    C_INV
  } cls_t;

  logic [5:0] sb6;
  logic [3:0] sb4;
  logic [4:0] d5;
  logic [2:0] d3;
  logic       v6, v4, k28, a7;
  cls_t       cls;

  assign sb6 = SUDI[9:4];
  assign sb4 = SUDI[3:0];

  always_comb begin
    d5  = '0;
    v6  = 1'b1;
    k28 = 1'b0;
    case (sb6)
      6'b100111, 6'b011000: d5 = 5'd0;
      6'b011101, 6'b100010: d5 = 5'd1;
      6'b101101, 6'b010010: d5 = 5'd2;
      6'b110001:            d5 = 5'd3;
      6'b110101, 6'b001010: d5 = 5'd4;
      6'b101001:            d5 = 5'd5;
      6'b011001:            d5 = 5'd6;
      6'b111000, 6'b000111: d5 = 5'd7;
      6'b111001, 6'b000110: d5 = 5'd8;
      6'b100101:            d5 = 5'd9;
      6'b010101:            d5 = 5'd10;
      6'b110100:            d5 = 5'd11;
      6'b001101:            d5 = 5'd12;
      6'b101100:            d5 = 5'd13;
      6'b011100:            d5 = 5'd14;
      6'b010111, 6'b101000: d5 = 5'd15;
      6'b011011, 6'b100100: d5 = 5'd16;
      6'b100011:            d5 = 5'd17;
      6'b010011:            d5 = 5'd18;
      6'b110010:            d5 = 5'd19;
      6'b001011:            d5 = 5'd20;
      6'b101010:            d5 = 5'd21;
      6'b011010:            d5 = 5'd22;
      6'b111010, 6'b000101: d5 = 5'd23;
      6'b110011, 6'b001100: d5 = 5'd24;
      6'b100110:            d5 = 5'd25;
      6'b010110:            d5 = 5'd26;
      6'b110110, 6'b001001: d5 = 5'd27;
      6'b001110:            d5 = 5'd28;
      6'b101110, 6'b010001: d5 = 5'd29;
      6'b011110, 6'b100001: d5 = 5'd30;
      6'b101011, 6'b010100: d5 = 5'd31;
      6'b001111, 6'b110000: k28 = 1'b1;
      default:              v6 = 1'b0;
    endcase
  end

  always_comb begin
    d3 = '0;
    v4 = 1'b1;
    a7 = 1'b0;
    case (sb4)
      4'b1011, 4'b0100: d3 = 3'd0;
      4'b1001:          d3 = 3'd1;
      4'b0101:          d3 = 3'd2;
      4'b1100, 4'b0011: d3 = 3'd3;
      4'b1101, 4'b0010: d3 = 3'd4;
      4'b1010:          d3 = 3'd5;
      4'b0110:          d3 = 3'd6;
      4'b1110, 4'b0001: d3 = 3'd7;
      4'b0111, 4'b1000: begin
        d3 = 3'd7;
        a7 = 1'b1;
      end
      default:          v4 = 1'b0;
    endcase
  end

  // Kx.7 control codes reuse data 6b blocks 23/27/29/30 with the A7 4b form
  always_comb begin
    if (!(v6 && v4))
      cls = C_INV;
    else if (SUDI == 10'h0FA || SUDI == 10'h305)
      cls = C_COMMA;
    else if (SUDI == 10'h368 || SUDI == 10'h097)
      cls = C_S;
    else if (SUDI == 10'h2E8 || SUDI == 10'h117)
      cls = C_T;
    else if (SUDI == 10'h3A8 || SUDI == 10'h057)
      cls = C_R;
    else if (k28 || (a7 && (d5 == 5'd23 || d5 == 5'd27 ||
                            d5 == 5'd29 || d5 == 5'd30)))
      cls = C_OTHK;
    else
      cls = C_DATA;
  end

  state_t               state_q, state_d;
  logic [7:0]           rxd_q, rxd_d;
  logic                 dv_q, dv_d;
  logic                 er_q, er_d;
  logic                 recv_q, recv_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 comma_e;

  assign comma_e = (cls == C_COMMA) && rx_even;

  always_comb begin
    state_d = state_q;
    rxd_d   = 8'h00;
    dv_d    = 1'b0;
    er_d    = 1'b0;
    cnt_d   = cnt_q;
    if (code_sync_status && cls == C_INV && cnt_q != '1)
      cnt_d = cnt_q + ERR_CNT_W'(1);
    if (!code_sync_status) begin
      state_d = S_LINK_FAILED;
      er_d    = (state_q == S_RECEIVE) || (state_q == S_T_SEEN);
    end else begin
      unique case (state_q)
        S_LINK_FAILED: state_d = S_WAIT_FOR_K;
        S_WAIT_FOR_K: begin
          if (comma_e)
            state_d = S_RX_K;
        end
        S_RX_K: begin
          state_d = (cls == C_DATA) ? S_IDLE_D : S_WAIT_FOR_K;
        end
        S_IDLE_D: begin
          if (comma_e) begin
            state_d = S_RX_K;
          end else if (cls == C_S && rx_even) begin
            state_d = S_RECEIVE;
            rxd_d   = 8'h55;
            dv_d    = 1'b1;
          end else begin
            state_d = S_WAIT_FOR_K;
          end
        end
        S_RECEIVE: begin
          unique case (cls)
            C_DATA: begin
              rxd_d = {d3, d5};
              dv_d  = 1'b1;
            end
            C_T: state_d = S_T_SEEN;
            C_COMMA: begin
              er_d    = 1'b1;
              state_d = rx_even ? S_RX_K : S_WAIT_FOR_K;
            end
            default: begin
              dv_d = 1'b1;
              er_d = 1'b1;
            end
          endcase
        end
        S_T_SEEN: begin
          er_d    = (cls != C_R);
          state_d = S_WAIT_FOR_K;
        end
        default: state_d = S_LINK_FAILED;
      endcase
    end
    recv_d = (state_d == S_RECEIVE) || (state_d == S_T_SEEN);
  end

  always_ff @(posedge clock) begin
    if (mr_main_reset) begin
      state_q <= S_LINK_FAILED;
      rxd_q   <= 8'h00;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      recv_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rxd_q   <= rxd_d;
      dv_q    <= dv_d;
      er_q    <= er_d;
      recv_q  <= recv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RXD           = rxd_q;
  assign RX_DV         = dv_q;
  assign RX_ER         = er_q;
  assign receiving     = recv_q;
  assign invalid_count = cnt_q;

endmodule
